// File: rtl/gpio_io_bridge.sv
// rtl/gpio_io_bridge.sv - board GPIO bridge: input sync/debounce, output change-detect to 74HC595-style serial link
module gpio_io_bridge #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCLK_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sw_raw,
  output logic [31:0] gpio_in,
  input  logic [31:0] gpio_out,
  output logic        sr_clk,
  output logic        sr_data,
  output logic        sr_latch,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  logic [31:0]   sync1, sync2, sync2_d;
  logic [CW-1:0] cnt;

  // Whole-word debounce: any movement of the synchronized word restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
      cnt     <= '0;
      gpio_in <= '0;
    end else begin
      sync1   <= sw_raw;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (sync2 == gpio_in) begin
        cnt <= '0;
      end else if (sync2 != sync2_d) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        gpio_in <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  state_t        state, state_n;
  logic [31:0]   shadow, pend_word, shifter, shifter_n;
  logic          pending;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [DW-1:0] div, div_n;
  logic          sr_clk_n;
  logic          change, consume, div_tc;

  assign change  = (gpio_out != shadow);
  assign consume = (state == IDLE) && pending;
  assign div_tc  = (div == DW'(SCLK_DIV - 1));

  // Single-entry mailbox: a new change always overwrites; set beats the FSM's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      pend_word <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= change && pending && !consume;
      if (change) begin
        shadow    <= gpio_out;
        pend_word <= gpio_out;
        pending   <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shifter <= '0;
      bit_cnt <= '0;
      div     <= '0;
      sr_clk  <= 1'b0;
    end else begin
      state   <= state_n;
      shifter <= shifter_n;
      bit_cnt <= bit_cnt_n;
      div     <= div_n;
      sr_clk  <= sr_clk_n;
    end
  end

  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    bit_cnt_n = bit_cnt;
    div_n     = div;
    sr_clk_n  = sr_clk;
    case (state)
      IDLE: begin
        if (pending) begin
          shifter_n = pend_word;
          bit_cnt_n = '0;
          div_n     = '0;
          sr_clk_n  = 1'b0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_tc) begin
          div_n    = '0;
          sr_clk_n = ~sr_clk;
          // Data advances only on the falling edge so it is stable at every rise.
          if (sr_clk) begin
            shifter_n = {shifter[30:0], 1'b0};
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              state_n = LATCH;
            end
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
      LATCH: begin
        if (div_tc) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sr_data  = (state == SHIFT) && shifter[31];
  assign sr_latch = (state == LATCH);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gpio_io_bridge.sv
// tb/tb_gpio_io_bridge.sv - scoreboard bench for gpio_io_bridge with a timing-level reference model
module tb_gpio_io_bridge;

  localparam int D  = 16;
  localparam int S  = 4;
  localparam int HL = D + 3;
  localparam int FRAME = 65 * S;

  logic        clk, rst;
  logic [31:0] sw_raw, gpio_in, gpio_out;
  logic        sr_clk, sr_data, sr_latch, busy, overrun;

  gpio_io_bridge #(.DEBOUNCE_CYCLES(D), .SCLK_DIV(S)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          start;
  } frame_t;

  frame_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ovr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: input accepted once the synchronized value has been
  // identical over D+1 samples; frames occupy a fixed 65*S-cycle slot.
  logic [31:0] hist[HL];
  logic [31:0] m_gpio_in, m_shadow, m_word;
  logic        m_pending, m_ovr;
  int          m_idle_edge;

  always @(posedge clk) begin
    logic same, cons;
    cyc++;
    if (rst) begin
      for (int i = 0; i < HL; i++) hist[i] = '0;
      m_gpio_in = '0; m_shadow = '0; m_word = '0;
      m_pending = 1'b0; m_ovr = 1'b0; m_idle_edge = 0;
      exp_q.delete();
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw_raw;
      same = 1'b1;
      for (int i = 3; i < HL; i++) if (hist[i] != hist[2]) same = 1'b0;
      if (same && hist[2] != m_gpio_in) m_gpio_in = hist[2];
      cons  = m_pending && (cyc >= m_idle_edge);
      m_ovr = 1'b0;
      if (cons) begin
        exp_q.push_back('{word: m_word, start: cyc});
        m_idle_edge = cyc + FRAME + 1;
        m_pending   = 1'b0;
      end
      if (gpio_out != m_shadow) begin
        if (m_pending) m_ovr = 1'b1;
        m_shadow  = gpio_out;
        m_word    = gpio_out;
        m_pending = 1'b1;
      end
    end
  end

  // Monitor: decodes the serial link and compares against the scoreboard.
  frame_t      cur;
  logic        cur_act = 1'b0, prev_busy = 1'b0, prev_clk = 1'b0;
  logic [31:0] cap;
  int          rises, latch_len, busy_len;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {gpio_in[27:0], sr_clk, sr_data, sr_latch, busy | overrun}, '0);
      cur_act = 1'b0; prev_busy = 1'b0; prev_clk = 1'b0;
    end else begin
      chk("gpio_in", gpio_in, m_gpio_in);
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (overrun) ovr_seen++;
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(busy), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("frame_start_cycle", 32'(cyc), 32'(cur.start));
          cur_act = 1'b1; cap = '0; rises = 0; latch_len = 0; busy_len = 0;
        end
      end
      if (busy) begin
        busy_len++;
        if (sr_clk && !prev_clk) begin
          cap = {cap[30:0], sr_data};
          rises++;
        end
        if (sr_latch) latch_len++;
        chk("latch_clk_overlap", 32'(sr_latch & sr_clk), 32'd0);
      end else begin
        chk("idle_serial_zero", {29'd0, sr_clk, sr_data, sr_latch}, '0);
      end
      if (!busy && prev_busy && cur_act) begin
        chk("frame_word", cap, cur.word);
        chk("frame_rises", 32'(rises), 32'd32);
        chk("latch_len", 32'(latch_len), 32'(S));
        chk("busy_len", 32'(busy_len), 32'(FRAME));
        cur_act = 1'b0;
      end
      prev_busy = busy;
      prev_clk  = sr_clk;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ovr0;
    rst = 1'b1; sw_raw = 32'hFFFF_FFFF; gpio_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_cycles(25);
    chk("debounce_initial", gpio_in, 32'hFFFF_FFFF);

    sw_raw = 32'hFFFF_FFFE;
    wait_cycles(10);
    sw_raw = 32'hFFFF_FFFF;
    wait_cycles(25);
    chk("glitch_rejected", gpio_in, 32'hFFFF_FFFF);
    sw_raw = 32'hFFFF_FFFE;
    wait_cycles(25);
    chk("hold_accepted", gpio_in, 32'hFFFF_FFFE);

    gpio_out = 32'hA5A5_0F0F;
    wait_cycles(300);

    ovr0 = ovr_seen;
    gpio_out = 32'hC3C3_3C3C;
    wait_cycles(50);
    gpio_out = 32'h1;
    wait_cycles(10);
    gpio_out = 32'h2;
    wait_cycles(600);
    chk("overrun_once", 32'(ovr_seen - ovr0), 32'd1);

    gpio_out = 32'h0F0F_F0F0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_outputs", {28'd0, sr_clk, sr_data, sr_latch, busy}, '0);
    @(negedge clk) gpio_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_cycles(5);
    gpio_out = 32'hDEAD_BEEF;
    wait_cycles(300);

    fork
      begin
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(0, 3) == 0) sw_raw = $urandom();
          else sw_raw = sw_raw ^ (32'h1 << $urandom_range(0, 31));
          wait_cycles($urandom_range(1, 30));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 4) != 0) gpio_out = $urandom();
          wait_cycles($urandom_range(1, 400));
        end
      end
    join
    wait_cycles(2 * FRAME + 10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
